operand_byte_sequencer: RTL and testbench
=========================================

# operand_byte_sequencer

Sequential, parametrised operand-field extractor for the x86-64 decode stage. It takes a per-instruction operand descriptor from the opcode decoder and consumes operand bytes (ModRM, SIB, displacement, immediate) from the fetch queue over as many cycles as needed. It emits one fully assembled operand record per instruction with a valid/ready handshake. It sits between the opcode decoder and the operand register-map logic, and replaces fixed 10-byte-window decoding.

## Interface
Parameters:
- FETCH_W, 4: bytes offered by the fetch queue per cycle (1..8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accepted on cmd_valid&cmd_ready.
- cmd_has_modrm  in  1  instruction carries a ModRM byte.
- cmd_imm_kind  in  3  immediate kind: 0 none, 1 Ib, 2 Iw, 3 Iz, 4 Iv; 5..7 reserved.
- cmd_rex_w  in  1  REX.W.
- cmd_opsize  in  1  0x66 prefix present.
- byte_valid  in  1  byte_data holds byte_count valid bytes.
- byte_count  in  $clog2(FETCH_W+1)  number of valid bytes, 0..FETCH_W.
- byte_data  in  FETCH_W*8  byte 0 in [7:0]; stream order is ascending byte lanes.
- byte_take  out  $clog2(FETCH_W+1)  bytes consumed this cycle (combinational).
- out_valid  out  1  record valid.
- out_ready  in  1  downstream accepts the record.
- out_modrm  out  8  ModRM byte (0 if none).
- out_sib  out  8  SIB byte (0 if none).
- out_has_sib  out  1  SIB present.
- out_disp  out  64  displacement, sign-extended.
- out_imm  out  64  immediate, extended per Operation.
- out_len  out  4  total operand bytes consumed.
- out_err  out  1  reserved cmd_imm_kind.

## Operation
- States: IDLE, MODRM, SIB, DISP, IMM, DONE.
- IDLE: cmd_ready=1. On accept, latch the descriptor and clear the record. Next state is the first non-empty field among MODRM/IMM, or DONE.
- Reserved imm_kind: go straight to DONE with out_err=1, out_len=0, and no bytes consumed.
- MODRM: take 1 byte. SIB is needed when mod!=11 and rm=100.
- Displacement length: mod=00 & rm=101 gives 4 (RIP-relative). mod=00 & SIB.base=101 gives 4. mod=01 gives 1. mod=10 gives 4. Otherwise 0.
- SIB: take 1 byte, then fix the displacement length.
- DISP/IMM: a remaining-byte counter is loaded on entry.
  - byte_take = min(byte_count, remaining) when byte_valid, else 0.
  - Bytes are assembled little-endian at offset (field_len - remaining).
  - A cycle never consumes across a field boundary.
- Immediate length: Ib=1, Iw=2, Iz=(opsize?2:4), Iv=(rex_w?8:(opsize?2:4)).
- Immediate extension: Ib and Iz are sign-extended to 64; Iw and Iv are zero-extended.
- Zero-length fields are skipped with no cycle spent.
- out_len is the sum of all bytes taken.
- DONE: out_valid=1, with all out_* stable until out_ready, then return to IDLE.

## Timing
- Reset: state IDLE, cmd_ready=1, byte_take=0, out_valid=0, and every out_* data/flag = 0. Reset mid-operation discards partial fields; flushing the queue is the fetch side's job.
- One cycle per MODRM/SIB state. DISP/IMM take ceil(len/FETCH_W) cycles when bytes are always available. byte_valid=0 stalls the current state.
- Latency from accept to out_valid = (states visited) + 1 cycle. A descriptor with no operands gives out_valid on the cycle after accept.
- cmd_ready=0 from accept until the record is handed off. Because cmd_ready is registered, the next accept occurs at the earliest one cycle after the out_valid&out_ready cycle.
- byte_take is never nonzero outside MODRM/SIB/DISP/IMM, and never exceeds byte_count.

## Configuration
- OPSEQ_RIPREL_EN defined: adds output out_rip_rel (1 bit, reset 0). It is 1 when ModRM has mod=00 & rm=101, and is registered with the record.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- FETCH_W=4, has_modrm, Ib, bytes 44 24 08 7F -> modrm=44, has_sib=1, sib=24, disp=8, imm=7F, len=4, byte_take 1,1,1,1 over four cycles.
- has_modrm=0, Iv, rex_w=1, bytes 88 77 66 55 44 33 22 11 -> IMM takes 4 then 4, imm=1122334455667788, len=8.
- ModRM 05, disp FC FF FF FF, Ib F0 -> disp=FFFFFFFFFFFFFFFC, imm=FFFFFFFFFFFFFFF0, len=6, out_rip_rel=1 with OPSEQ_RIPREL_EN.
- Iz with opsize=1, bytes 34 12; byte_valid low for 3 cycles mid-field; out_ready low for 5 cycles -> imm=0000000000001234, len=2, no bytes taken while stalled, record stable while out_ready is low.
- cmd_imm_kind=6 -> out_valid the cycle after accept, out_err=1, len=0, byte_take=0 throughout.
- Assert reset during the DISP of ModRM 80 -> all outputs 0 and IDLE; a following descriptor decodes correctly from fresh bytes.

Source files
------------

// File: rtl/operand_byte_sequencer_if.sv
// Bus bundle for operand_byte_sequencer: descriptor handshake, fetch byte
// window and the assembled operand record.
// Optional macro OPSEQ_RIPREL_EN adds the out_rip_rel record flag.
interface operand_byte_sequencer_if #(
    parameter int FETCH_W = 4
);
    localparam int TW = $clog2(FETCH_W + 1);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_has_modrm;
    logic [2:0]        cmd_imm_kind;
    logic              cmd_rex_w;
    logic              cmd_opsize;

    logic              byte_valid;
    logic [TW-1:0]     byte_count;
    logic [FETCH_W*8-1:0] byte_data;
    logic [TW-1:0]     byte_take;

    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_modrm;
    logic [7:0]        out_sib;
    logic              out_has_sib;
    logic [63:0]       out_disp;
    logic [63:0]       out_imm;
    logic [3:0]        out_len;
    logic              out_err;
`ifdef OPSEQ_RIPREL_EN
    logic              out_rip_rel;
`endif

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_has_modrm, cmd_imm_kind, cmd_rex_w, cmd_opsize,
        input  byte_valid, byte_count, byte_data, out_ready,
        output cmd_ready, byte_take, out_valid, out_modrm, out_sib, out_has_sib,
        output out_disp, out_imm, out_len, out_err
`ifdef OPSEQ_RIPREL_EN
        , output out_rip_rel
`endif
    );

    // Decoder / fetch / consumer side
    modport master (
        output cmd_valid, cmd_has_modrm, cmd_imm_kind, cmd_rex_w, cmd_opsize,
        output byte_valid, byte_count, byte_data, out_ready,
        input  cmd_ready, byte_take, out_valid, out_modrm, out_sib, out_has_sib,
        input  out_disp, out_imm, out_len, out_err
`ifdef OPSEQ_RIPREL_EN
        , input out_rip_rel
`endif
    );
endinterface

// File: rtl/operand_byte_sequencer.sv
// Multi-cycle x86-64 operand field extractor: walks ModRM, SIB,
// displacement and immediate bytes out of the fetch window and presents one
// assembled operand record per accepted descriptor.
// Optional macro OPSEQ_RIPREL_EN adds the out_rip_rel record flag.
module operand_byte_sequencer #(
    parameter int FETCH_W = 4
) (
    input  logic clk,
    input  logic reset,
    operand_byte_sequencer_if.slave bus
);
    localparam int TW = $clog2(FETCH_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  imm_len_q, imm_len_d;
    logic        imm_sgn_q, imm_sgn_d;
    logic [3:0]  rem_q, rem_d;
    logic [3:0]  flen_q, flen_d;
    logic [7:0]  modrm_q, modrm_d;
    logic [7:0]  sib_q, sib_d;
    logic        has_sib_q, has_sib_d;
    logic [63:0] disp_q, disp_d;
    logic [63:0] imm_q, imm_d;
    logic [3:0]  len_q, len_d;
    logic        err_q, err_d;
`ifdef OPSEQ_RIPREL_EN
    logic        rip_q, rip_d;
`endif

    logic [3:0]  cnt4;
    logic [3:0]  need4;
    logic [3:0]  take4;
    logic [7:0]  lane0;
    logic        acc_err;
    logic        acc_imm_sgn;
    logic [3:0]  acc_imm_len;
    logic [3:0]  modrm_dlen;
    logic [3:0]  sib_dlen;
    logic [63:0] merged;
    logic        advance;
    logic [3:0]  next_dlen;

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [3:0] n,
                                           input logic sgn);
        logic [63:0] r;
        case (n)
            4'd1:    r = {{56{sgn & v[7]}},  v[7:0]};
            4'd2:    r = {{48{sgn & v[15]}}, v[15:0]};
            4'd4:    r = {{32{sgn & v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Descriptor decode, per-state byte demand and displacement sizing
    always_comb begin
        acc_err     = (bus.cmd_imm_kind > 3'd4);
        acc_imm_sgn = (bus.cmd_imm_kind == 3'd1) || (bus.cmd_imm_kind == 3'd3);
        case (bus.cmd_imm_kind)
            3'd1:    acc_imm_len = 4'd1;
            3'd2:    acc_imm_len = 4'd2;
            3'd3:    acc_imm_len = bus.cmd_opsize ? 4'd2 : 4'd4;
            3'd4:    acc_imm_len = bus.cmd_rex_w ? 4'd8 : (bus.cmd_opsize ? 4'd2 : 4'd4);
            default: acc_imm_len = 4'd0;
        endcase

        lane0 = bus.byte_data[7:0];
        cnt4  = 4'(bus.byte_count);
        case (state_q)
            S_MODRM, S_SIB: need4 = 4'd1;
            S_DISP, S_IMM:  need4 = rem_q;
            default:        need4 = 4'd0;
        endcase
        take4 = '0;
        if (bus.byte_valid) take4 = (cnt4 < need4) ? cnt4 : need4;

        case (lane0[7:6])
            2'b00:   modrm_dlen = (lane0[2:0] == 3'b101) ? 4'd4 : 4'd0;
            2'b01:   modrm_dlen = 4'd1;
            2'b10:   modrm_dlen = 4'd4;
            default: modrm_dlen = 4'd0;
        endcase
        case (modrm_q[7:6])
            2'b00:   sib_dlen = (lane0[2:0] == 3'b101) ? 4'd4 : 4'd0;
            2'b01:   sib_dlen = 4'd1;
            2'b10:   sib_dlen = 4'd4;
            default: sib_dlen = 4'd0;
        endcase
    end

    // Little-endian placement of this cycle's bytes into the active field
    always_comb begin
        int unsigned off;
        int unsigned idx;
        merged = (state_q == S_IMM) ? imm_q : disp_q;
        off    = 32'(flen_q - rem_q);
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            idx = off + i;
            if (i < 32'(take4) && idx < 8) merged[idx*8 +: 8] = bus.byte_data[i*8 +: 8];
        end
    end

    // Next-state and record update
    always_comb begin
        state_d   = state_q;
        imm_len_d = imm_len_q;
        imm_sgn_d = imm_sgn_q;
        rem_d     = rem_q;
        flen_d    = flen_q;
        modrm_d   = modrm_q;
        sib_d     = sib_q;
        has_sib_d = has_sib_q;
        disp_d    = disp_q;
        imm_d     = imm_q;
        len_d     = len_q + take4;
        err_d     = err_q;
`ifdef OPSEQ_RIPREL_EN
        rip_d     = rip_q;
`endif
        advance   = 1'b0;
        next_dlen = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    imm_len_d = acc_imm_len;
                    imm_sgn_d = acc_imm_sgn;
                    modrm_d   = '0;
                    sib_d     = '0;
                    has_sib_d = 1'b0;
                    disp_d    = '0;
                    imm_d     = '0;
                    len_d     = '0;
                    err_d     = acc_err;
`ifdef OPSEQ_RIPREL_EN
                    rip_d     = 1'b0;
`endif
                    if (acc_err) begin
                        state_d = S_DONE;
                    end else if (bus.cmd_has_modrm) begin
                        state_d = S_MODRM;
                    end else if (acc_imm_len != '0) begin
                        state_d = S_IMM;
                        rem_d   = acc_imm_len;
                        flen_d  = acc_imm_len;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MODRM: begin
                if (take4 != '0) begin
                    modrm_d = lane0;
`ifdef OPSEQ_RIPREL_EN
                    rip_d   = (lane0[7:6] == 2'b00) && (lane0[2:0] == 3'b101);
`endif
                    if (lane0[7:6] != 2'b11 && lane0[2:0] == 3'b100) begin
                        state_d = S_SIB;
                    end else begin
                        advance   = 1'b1;
                        next_dlen = modrm_dlen;
                    end
                end
            end
            S_SIB: begin
                if (take4 != '0) begin
                    sib_d     = lane0;
                    has_sib_d = 1'b1;
                    advance   = 1'b1;
                    next_dlen = sib_dlen;
                end
            end
            S_DISP: begin
                if (take4 != '0) begin
                    rem_d = rem_q - take4;
                    if (take4 == rem_q) begin
                        disp_d  = extend(merged, flen_q, 1'b1);
                        advance = 1'b1;
                    end else begin
                        disp_d = merged;
                    end
                end
            end
            S_IMM: begin
                if (take4 != '0) begin
                    rem_d = rem_q - take4;
                    if (take4 == rem_q) begin
                        imm_d   = extend(merged, flen_q, imm_sgn_q);
                        state_d = S_DONE;
                    end else begin
                        imm_d = merged;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Zero-length displacement/immediate fields are skipped in the same cycle
        if (advance) begin
            if (next_dlen != '0) begin
                state_d = S_DISP;
                rem_d   = next_dlen;
                flen_d  = next_dlen;
            end else if (imm_len_q != '0) begin
                state_d = S_IMM;
                rem_d   = imm_len_q;
                flen_d  = imm_len_q;
            end else begin
                state_d = S_DONE;
            end
        end
    end

    // State and record registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            imm_len_q <= '0;
            imm_sgn_q <= 1'b0;
            rem_q     <= '0;
            flen_q    <= '0;
            modrm_q   <= '0;
            sib_q     <= '0;
            has_sib_q <= 1'b0;
            disp_q    <= '0;
            imm_q     <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            imm_len_q <= imm_len_d;
            imm_sgn_q <= imm_sgn_d;
            rem_q     <= rem_d;
            flen_q    <= flen_d;
            modrm_q   <= modrm_d;
            sib_q     <= sib_d;
            has_sib_q <= has_sib_d;
            disp_q    <= disp_d;
            imm_q     <= imm_d;
            len_q     <= len_d;
            err_q     <= err_d;
        end
    end

`ifdef OPSEQ_RIPREL_EN
    // RIP-relative flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rip_q <= 1'b0;
        else       rip_q <= rip_d;
    end
    assign bus.out_rip_rel = rip_q;
`endif

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.byte_take   = TW'(take4);
    assign bus.out_modrm   = modrm_q;
    assign bus.out_sib     = sib_q;
    assign bus.out_has_sib = has_sib_q;
    assign bus.out_disp    = disp_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_len     = len_q;
    assign bus.out_err     = err_q;
endmodule

// File: tb/tb_operand_byte_sequencer.sv
// Randomized self-checking bench for operand_byte_sequencer with a
// byte-stream parsing reference model.
module tb_operand_byte_sequencer;
    localparam int FW = 4;
    localparam int TW = $clog2(FW + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_byte_sequencer_if #(.FETCH_W(FW)) bus ();
    operand_byte_sequencer #(.FETCH_W(FW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  stream [16];
    logic [7:0]  e_modrm, e_sib;
    logic        e_has_sib, e_err, e_rip;
    logic [63:0] e_disp, e_imm;
    int unsigned e_len, e_lat, nfld;
    int unsigned fld [4];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_stream(input logic [127:0] v);
        for (int unsigned i = 0; i < 16; i++) stream[i] = v[i*8 +: 8];
    endtask

    task automatic drive_lanes(input int unsigned base);
        logic [FW*8-1:0] d;
        for (int unsigned i = 0; i < FW; i++)
            d[i*8 +: 8] = (base + i < 16) ? stream[base + i] : 8'($urandom);
        bus.byte_data = d;
    endtask

    function automatic logic [63:0] field_val(input int unsigned p, input int unsigned n,
                                              input bit sgn);
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < n; i++) v = v | (64'(stream[p + i]) << (8 * i));
        if (sgn && n < 8 && stream[p + n - 1][7]) v = v | ({64{1'b1}} << (8 * n));
        return v;
    endfunction

    task automatic add_field(input int unsigned n, inout int unsigned pos);
        fld[nfld] = n;
        nfld++;
        e_lat += (n + FW - 1) / FW;
        pos += n;
    endtask

    // Parse the byte stream as an x86 operand tail for the given descriptor
    task automatic build_model(input logic hm, input logic [2:0] kind, input logic rw,
                               input logic os);
        int unsigned pos = 0;
        int unsigned ilen, dlen;
        bit isgn;
        logic [1:0] md;
        logic [2:0] rm;
        e_modrm = '0; e_sib = '0; e_has_sib = 0; e_err = 0; e_rip = 0;
        e_disp = '0; e_imm = '0; e_len = 0; e_lat = 1; nfld = 0;
        if (kind > 4) begin
            e_err = 1;
            return;
        end
        case (kind)
            3'd1:    ilen = 1;
            3'd2:    ilen = 2;
            3'd3:    ilen = os ? 2 : 4;
            3'd4:    ilen = rw ? 8 : (os ? 2 : 4);
            default: ilen = 0;
        endcase
        isgn = (kind == 3'd1) || (kind == 3'd3);
        if (hm) begin
            e_modrm = stream[0];
            md = e_modrm[7:6];
            rm = e_modrm[2:0];
            e_rip = (md == 2'd0) && (rm == 3'd5);
            add_field(1, pos);
            if (md != 2'd3 && rm == 3'd4) begin
                e_has_sib = 1;
                e_sib = stream[pos];
                add_field(1, pos);
            end
            if (md == 2'd1) dlen = 1;
            else if (md == 2'd2) dlen = 4;
            else if (md == 2'd0 && (rm == 3'd5 || (e_has_sib && e_sib[2:0] == 3'd5))) dlen = 4;
            else dlen = 0;
            if (dlen != 0) begin
                e_disp = field_val(pos, dlen, 1);
                add_field(dlen, pos);
            end
        end
        if (ilen != 0) begin
            e_imm = field_val(pos, ilen, isgn);
            add_field(ilen, pos);
        end
        e_len = pos;
    endtask

    function automatic int unsigned field_left(input int unsigned c);
        int unsigned acc = 0;
        for (int unsigned k = 0; k < nfld; k++) begin
            if (c < acc + fld[k]) return acc + fld[k] - c;
            acc += fld[k];
        end
        return 0;
    endfunction

    task automatic check_record(input string t);
        check_eq({t, ".valid"},   64'(bus.out_valid),   64'(1));
        check_eq({t, ".modrm"},   64'(bus.out_modrm),   64'(e_modrm));
        check_eq({t, ".sib"},     64'(bus.out_sib),     64'(e_sib));
        check_eq({t, ".has_sib"}, 64'(bus.out_has_sib), 64'(e_has_sib));
        check_eq({t, ".disp"},    bus.out_disp,         e_disp);
        check_eq({t, ".imm"},     bus.out_imm,          e_imm);
        check_eq({t, ".len"},     64'(bus.out_len),     64'(e_len));
        check_eq({t, ".err"},     64'(bus.out_err),     64'(e_err));
`ifdef OPSEQ_RIPREL_EN
        check_eq({t, ".rip_rel"}, 64'(bus.out_rip_rel), 64'(e_rip));
`endif
    endtask

    task automatic check_reset(input string t);
        check_eq({t, ".cmd_ready"}, 64'(bus.cmd_ready),   64'(1));
        check_eq({t, ".take"},      64'(bus.byte_take),   64'(0));
        check_eq({t, ".valid"},     64'(bus.out_valid),   64'(0));
        check_eq({t, ".modrm"},     64'(bus.out_modrm),   64'(0));
        check_eq({t, ".sib"},       64'(bus.out_sib),     64'(0));
        check_eq({t, ".has_sib"},   64'(bus.out_has_sib), 64'(0));
        check_eq({t, ".disp"},      bus.out_disp,         64'(0));
        check_eq({t, ".imm"},       bus.out_imm,          64'(0));
        check_eq({t, ".len"},       64'(bus.out_len),     64'(0));
        check_eq({t, ".err"},       64'(bus.out_err),     64'(0));
`ifdef OPSEQ_RIPREL_EN
        check_eq({t, ".rip_rel"},   64'(bus.out_rip_rel), 64'(0));
`endif
    endtask

    // mode 0: random byte availability; 1: full window every cycle;
    // 2: one byte, three stall cycles, then full window
    task automatic run_txn(input logic hm, input logic [2:0] kind, input logic rw,
                           input logic os, input int unsigned mode, input int unsigned hold);
        int unsigned consumed = 0;
        int unsigned cycles = 0;
        int unsigned tk, left, want;
        bit seen = 0;
        logic bv;
        logic [TW-1:0] bc;
        build_model(hm, kind, rw, os);
        bus.cmd_valid = 1'b1;
        bus.cmd_has_modrm = hm;
        bus.cmd_imm_kind = kind;
        bus.cmd_rex_w = rw;
        bus.cmd_opsize = os;
        bus.out_ready = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_count = TW'(FW);
        drive_lanes(0);
        @(negedge clk);
        check_eq("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1));
        check_eq("take_idle", 64'(bus.byte_take), 64'(0));
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_has_modrm = 1'($urandom);
        bus.cmd_imm_kind = 3'($urandom);
        while (!seen && cycles < 200) begin
            cycles++;
            if (mode == 1) begin
                bv = 1'b1; bc = TW'(FW);
            end else if (mode == 2) begin
                if (cycles == 1) begin bv = 1'b1; bc = TW'(1); end
                else if (cycles <= 4) begin bv = 1'b0; bc = TW'($urandom_range(0, FW)); end
                else begin bv = 1'b1; bc = TW'(FW); end
            end else begin
                bv = ($urandom_range(0, 3) != 0);
                bc = TW'($urandom_range(0, FW));
            end
            bus.byte_valid = bv;
            bus.byte_count = bc;
            drive_lanes(consumed);
            @(negedge clk);
            left = field_left(consumed);
            want = bv ? ((32'(bc) < left) ? 32'(bc) : left) : 0;
            check_eq("byte_take", 64'(bus.byte_take), 64'(want));
            tk = 32'(bus.byte_take);
            if (bus.out_valid) begin
                seen = 1;
            end else begin
                check_eq("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
                @(posedge clk); #1;
                consumed += tk;
            end
        end
        if (!seen) begin
            check_eq("out_valid_timeout", 64'(bus.out_valid), 64'(1));
        end else begin
            check_eq("consumed", 64'(consumed), 64'(e_len));
            if (mode == 1) check_eq("latency", 64'(cycles), 64'(e_lat));
            check_record("rec_first");
            for (int unsigned h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                bus.byte_valid = 1'($urandom);
                bus.byte_count = TW'($urandom_range(0, FW));
                drive_lanes(consumed);
                @(negedge clk);
                check_record("rec_hold");
                check_eq("take_done", 64'(bus.byte_take), 64'(0));
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            @(negedge clk);
            check_record("rec_handoff");
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            @(negedge clk);
            check_eq("out_valid_after", 64'(bus.out_valid), 64'(0));
            check_eq("cmd_ready_after", 64'(bus.cmd_ready), 64'(1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;
        logic [2:0] kind;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_has_modrm = 1'b1;
        bus.cmd_imm_kind = 3'd1;
        bus.cmd_rex_w = 1'b0;
        bus.cmd_opsize = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_count = TW'(FW);
        bus.byte_data = '1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // ModRM 44 + SIB 24 + disp8 + Ib
        set_stream(128'h7F082444);
        run_txn(1'b1, 3'd1, 1'b0, 1'b0, 1, 1);
        // Iv with REX.W, two full windows
        set_stream(128'h1122334455667788);
        run_txn(1'b0, 3'd4, 1'b1, 1'b0, 1, 0);
        // RIP-relative disp32 + Ib, both negative
        set_stream(128'hF0FFFFFFFC05);
        run_txn(1'b1, 3'd1, 1'b0, 1'b0, 1, 2);
        // Iz with 0x66, mid-field stall, long downstream backpressure
        set_stream(128'h1234);
        run_txn(1'b0, 3'd3, 1'b0, 1'b1, 2, 5);
        // Reserved immediate kind
        set_stream(128'h0102030405060708);
        run_txn(1'b1, 3'd6, 1'b0, 1'b0, 1, 1);
        // No operands at all
        run_txn(1'b0, 3'd0, 1'b0, 1'b0, 1, 0);

        // Reset in the middle of a disp32 after ModRM 80
        set_stream(128'h4433221180);
        bus.cmd_valid = 1'b1;
        bus.cmd_has_modrm = 1'b1;
        bus.cmd_imm_kind = 3'd0;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_count = TW'(1);
        drive_lanes(0);
        @(negedge clk);
        check_eq("mid_take_modrm", 64'(bus.byte_take), 64'(1));
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_take_stall", 64'(bus.byte_take), 64'(0));
        #1;
        reset = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_count = TW'(FW);
        #1;
        check_reset("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        set_stream(128'h66_78563412_0C_84);
        run_txn(1'b1, 3'd2, 1'b0, 1'b0, 1, 0);

        // Randomized descriptors and byte availability
        for (int t = 0; t < 60; t++) begin
            for (int unsigned i = 0; i < 16; i++) stream[i] = 8'($urandom);
            case ($urandom_range(0, 3))
                0: stream[0][2:0] = 3'd4;
                1: stream[0][2:0] = 3'd5;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) stream[1][2:0] = 3'd5;
            r = $urandom_range(0, 9);
            kind = (r < 8) ? 3'(r % 5) : 3'($urandom_range(5, 7));
            run_txn(($urandom_range(0, 3) != 0), kind, 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
